// File: rtl/muldiv_hilo.sv
// HI/LO multiply-divide unit: single-cycle MULT and MTHI/MTLO, iterative restoring DIV.
// The divider is built only when MULDIV_DIV_EN is defined; otherwise DIV reports div_by_zero.
module muldiv_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] OpMult = 2'b00;
  localparam logic [1:0] OpDiv  = 2'b01;
  localparam logic [1:0] OpMthi = 2'b10;
  localparam logic [1:0] OpMtlo = 2'b11;

  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               idle, accept;

  // Sign- or zero-extending to full width makes one multiplier serve both signednesses.
  always_comb begin
    a_ext   = {{WIDTH{is_signed & src_a[WIDTH-1]}}, src_a};
    b_ext   = {{WIDTH{is_signed & src_b[WIDTH-1]}}, src_b};
    product = a_ext * b_ext;
  end

`ifdef MULDIV_DIV_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StDivIter, StDivFix} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic             q_neg_q, r_neg_q;
  logic             a_neg, b_neg, sub_ok;
  logic [WIDTH-1:0] abs_a, abs_b, rem_next;
  logic [WIDTH:0]   rem_shift;

  always_comb begin
    a_neg     = is_signed & src_a[WIDTH-1];
    b_neg     = is_signed & src_b[WIDTH-1];
    abs_a     = a_neg ? -src_a : src_a;
    abs_b     = b_neg ? -src_b : src_b;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    sub_ok    = rem_shift >= {1'b0, dvs_q};
    // Only used when sub_ok, so the true difference fits in WIDTH bits.
    rem_next  = rem_shift[WIDTH-1:0] - dvs_q;
    idle      = (state_q == StIdle);
  end
`else
  always_comb idle = 1'b1;
`endif

  always_comb accept = start & ~flush & idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_out      <= '0;
      lo_out      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        unique case (op)
          OpMult: begin
            hi_out <= product[2*WIDTH-1:WIDTH];
            lo_out <= product[WIDTH-1:0];
            done   <= 1'b1;
          end
          OpMthi: begin
            hi_out <= src_a;
            done   <= 1'b1;
          end
          OpMtlo: begin
            lo_out <= src_a;
            done   <= 1'b1;
          end
          OpDiv: begin
`ifdef MULDIV_DIV_EN
            if (src_b == '0) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              quo_q   <= abs_a;
              rem_q   <= '0;
              dvs_q   <= abs_b;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              cnt_q   <= CntW'(WIDTH);
              busy    <= 1'b1;
              state_q <= StDivIter;
            end
`else
            done        <= 1'b1;
            div_by_zero <= 1'b1;
`endif
          end
        endcase
      end
`ifdef MULDIV_DIV_EN
      if (flush) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StDivIter: begin
            rem_q <= sub_ok ? rem_next : rem_shift[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], sub_ok};
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_q <= StDivFix;
          end
          StDivFix: begin
            lo_out  <= q_neg_q ? -quo_q : quo_q;
            hi_out  <= r_neg_q ? -rem_q : rem_q;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end
          default: ;
        endcase
      end
`endif
    end
  end

endmodule
